// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic [WORD_BYTES-1:0] be;
  } dmem_req_t;

  // Misaligned, below base (borrow of the subtraction) or past the last word.
  function automatic logic dmem_fault(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [32:0] diff;
    diff = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] != 2'b00) || diff[32] || ((diff[31:0] >> 2) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane writes and a registered read; no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [WORD_BYTES-1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (be[2'(b)]) mem[addr][2'(b)] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state memory responder: latches a request, waits, then commits/reads and pulses ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  MemWrite,
  input  logic [DATA_W-1:0]     DataAdr,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [WORD_BYTES-1:0] ByteEn,
  output logic [DATA_W-1:0]     ReadData,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  dmem_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          accept, resp_go;

  dmem_req_t     in_txn, txn_q, cur;
  logic          in_fault, fault_q, cur_fault;
  logic [31:0]   cur_off;
  logic [AW-1:0] cur_idx;
  logic          rd_valid;
  logic          ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign in_txn   = '{wr: MemWrite, adr: DataAdr, wdata: WriteData, be: ByteEn};
  assign in_fault = dmem_fault(DataAdr, BASE_ADDR, 32'(DEPTH_WORDS));

  // With zero wait states the RESP edge is the acceptance edge, so use live inputs in IDLE.
  assign cur       = (state == IDLE) ? in_txn : txn_q;
  assign cur_fault = (state == IDLE) ? in_fault : fault_q;
  assign cur_off   = cur.adr - BASE_ADDR;
  assign cur_idx   = cur_off[AW+1:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    resp_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_d  = CW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            resp_go = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = RESP;
          resp_go = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      txn_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      ready <= resp_go;
      err   <= resp_go && cur_fault;
      busy  <= (state_d != IDLE);
      if (accept) begin
        txn_q   <= in_txn;
        fault_q <= in_fault;
      end
      // Loads and faults replace the visible read data; stores leave it held.
      if (resp_go && (cur_fault || !cur.wr)) rd_valid <= !cur_fault;
    end
  end

  assign ram_en   = reset && resp_go && !cur_fault;
  assign ReadData = rd_valid ? ram_rdata : '0;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .wr    (cur.wr),
    .be    (cur.be),
    .addr  (cur_idx),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

endmodule
